// File: rtl/word_demux4_pkg.sv
// Shared constants and types for the word_demux4 four-way word router.
// Optional broadcast feature is selected with WORD_DEMUX4_BCAST_EN.
package word_demux4_pkg;

    localparam int NUM_CH        = 4;
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

    // Destination channel index, 0..NUM_CH-1.
    typedef logic [1:0] ch_sel_t;

    // One-hot mask of the channel addressed by sel.
    function automatic logic [NUM_CH-1:0] ch_onehot(input ch_sel_t sel);
        logic [NUM_CH-1:0] mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Per-channel queue for word_demux4. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
// The head word reads as zero while the queue is empty.
module demux_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic             w_do_push;
    logic             w_do_pop;

    // Full when the wrap bits differ but the index bits match; empty when equal.
    always_comb begin
        o_empty    = (r_wr_ptr == r_rd_ptr);
        o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_do_push  = i_push && !o_full;
        w_do_pop   = i_pop && !o_empty;
        o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    end

    // Pointer update; reset empties the queue immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/word_demux4.sv
// word_demux4: routes each accepted input word into one of four per-channel
// queues selected by in_sel. Defining WORD_DEMUX4_BCAST_EN adds in_bcast,
// which pushes the word into all four queues at once.
//
// Handshakes: a word moves on every rising edge where valid && ready.
// in_ready is derived only from registered queue state and the select
// inputs, never from out_ready, so a word entering a channel is first
// visible one cycle later (no same-cycle pass-through).
module word_demux4
    import word_demux4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [WIDTH-1:0]  in_data,
`ifdef WORD_DEMUX4_BCAST_EN
    input  logic              in_bcast,
`endif
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [WIDTH-1:0]  out_data0,
    output logic [WIDTH-1:0]  out_data1,
    output logic [WIDTH-1:0]  out_data2,
    output logic [WIDTH-1:0]  out_data3
);

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_sel_mask;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [WIDTH-1:0]  w_head [NUM_CH];

    // Target mask and acceptance: ready only if no targeted channel is full.
    always_comb begin
`ifdef WORD_DEMUX4_BCAST_EN
        w_sel_mask = in_bcast ? {NUM_CH{1'b1}} : ch_onehot(ch_sel_t'(in_sel));
`else
        w_sel_mask = ch_onehot(ch_sel_t'(in_sel));
`endif
        in_ready   = ~|(w_full & w_sel_mask);
        w_push     = {NUM_CH{in_valid && in_ready}} & w_sel_mask;
        out_valid  = ~w_empty;
        w_pop      = out_valid & out_ready;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            demux_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_push      (w_push[g]),
                .i_push_data (in_data),
                .i_pop       (w_pop[g]),
                .o_pop_data  (w_head[g]),
                .o_full      (w_full[g]),
                .o_empty     (w_empty[g])
            );
        end
    endgenerate

    // Head words of each channel; zero whenever the channel is empty.
    always_comb begin
        out_data0 = w_head[0];
        out_data1 = w_head[1];
        out_data2 = w_head[2];
        out_data3 = w_head[3];
    end

endmodule
